// File: rtl/jh_pkg.sv
// ---------------------------------------------------------------------------
// jh_pkg -- shared definitions for the JH E8 permutation engine.
//
// Contents:
//   ROUNDS, widths   round count and nibble counts of the state/constant paths
//   C0               first 256-bit round constant
//   S0_TAB, S1_TAB   the two JH 4-bit S-boxes, entry 0 in the top nibble
//   state_t          control FSM encoding for f8
//   sbox()           S-box lookup with selector
//   lmix()           JH linear transform L on a nibble pair
//   hpos()           JH bit index -> bus bit position
//   group()/degroup() bus <-> 256-nibble grouped state
//
// Grouped-state packing: nibble n lives at [1023-4n -: 4], and inside a nibble
// the first JH bit (bit 0) is the MSB.  The constant path uses the same
// MSB-first nibble packing, so a 256-bit constant is its own nibble array.
// ---------------------------------------------------------------------------
package jh_pkg;

    localparam int ROUNDS    = 42;
    localparam int STATE_W   = 1024;
    localparam int CONST_W   = 256;
    localparam int NIB_STATE = STATE_W / 4;
    localparam int NIB_CONST = CONST_W / 4;
    localparam int CNT_W     = 6;

    localparam logic [CONST_W-1:0] C0 =
        256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;

    localparam logic [63:0] S0_TAB = 64'h904BDC3F1A26758E;
    localparam logic [63:0] S1_TAB = 64'h3C6D5719F204BAE8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shifting the table left by 4*x brings entry x to the top nibble.
    function automatic logic [3:0] sbox(input logic sel, input logic [3:0] x);
        logic [63:0] t;
        t = (sel ? S1_TAB : S0_TAB) << {x, 2'b00};
        return t[63:60];
    endfunction

    // L(A,B) -> {C,D}; bit k of the JH notation is bit [3-k] here.
    function automatic logic [7:0] lmix(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] c;
        logic [3:0] d;
        d[3] = b[3] ^ a[2];
        d[2] = b[2] ^ a[1];
        d[1] = b[1] ^ a[0] ^ a[3];
        d[0] = b[0] ^ a[3];
        c[3] = a[3] ^ d[2];
        c[2] = a[2] ^ d[1];
        c[1] = a[1] ^ d[0] ^ d[3];
        c[0] = a[0] ^ d[3];
        return {c, d};
    endfunction

    // JH bit k sits in byte k/8 (MSB first); bytes pair up into 16-bit words
    // with the even byte in the upper half.
    function automatic logic [9:0] hpos(input int k);
        int p;
        p = 16 * (k / 16) + (((k / 8) % 2 == 1) ? 7 : 15) - (k % 8);
        return p[9:0];
    endfunction

    function automatic logic [STATE_W-1:0] group(input logic [STATE_W-1:0] bus);
        logic [STATE_W-1:0] g;
        g = '0;
        for (int i = 0; i < 128; i++) begin
            g[1023-8*i -: 4] = {bus[hpos(i)],       bus[hpos(i + 256)],
                                bus[hpos(i + 512)], bus[hpos(i + 768)]};
            g[1019-8*i -: 4] = {bus[hpos(i + 128)], bus[hpos(i + 384)],
                                bus[hpos(i + 640)], bus[hpos(i + 896)]};
        end
        return g;
    endfunction

    function automatic logic [STATE_W-1:0] degroup(input logic [STATE_W-1:0] g);
        logic [STATE_W-1:0] bus;
        logic [3:0]         na;
        logic [3:0]         nb;
        bus = '0;
        for (int i = 0; i < 128; i++) begin
            na = g[1023-8*i -: 4];
            nb = g[1019-8*i -: 4];
            bus[hpos(i)]       = na[3];
            bus[hpos(i + 256)] = na[2];
            bus[hpos(i + 512)] = na[1];
            bus[hpos(i + 768)] = na[0];
            bus[hpos(i + 128)] = nb[3];
            bus[hpos(i + 384)] = nb[2];
            bus[hpos(i + 640)] = nb[1];
            bus[hpos(i + 896)] = nb[0];
        end
        return bus;
    endfunction

endpackage

// File: rtl/f8_if.sv
// ---------------------------------------------------------------------------
// f8_if -- request/result bundle of the f8 permutation engine.
//
// Signals:
//   start      1     single-cycle request, captures state_in
//   state_in   1024  JH state to permute
//   state_out  1024  E8 result, held until the next completion
//   done       1     one-cycle pulse when state_out updates
//
// Modports: master drives requests (bench/host), slave is the engine.
// ---------------------------------------------------------------------------
interface f8_if;
    import jh_pkg::*;

    logic               start;
    logic [STATE_W-1:0] state_in;
    logic [STATE_W-1:0] state_out;
    logic               done;

    modport master (
        output start,
        output state_in,
        input  state_out,
        input  done
    );

    modport slave (
        input  start,
        input  state_in,
        output state_out,
        output done
    );

endinterface

// File: rtl/jh_round.sv
// ---------------------------------------------------------------------------
// jh_round -- one combinational JH round R_d on NIB nibbles.
//
// Ports:
//   state_i  [4*NIB-1:0]  input nibbles, nibble 0 in the top bits
//   sel_i    [NIB-1:0]    S-box select per nibble, nibble 0 in the MSB
//                         (0 -> S0, 1 -> S1)
//   state_o  [4*NIB-1:0]  round output, same packing
//
// NIB = 256 gives the state round R8, NIB = 64 with sel_i = 0 gives the
// constant-generation round R6.
// ---------------------------------------------------------------------------
module jh_round
    import jh_pkg::*;
#(
    parameter int NIB = NIB_STATE
) (
    input  logic [4*NIB-1:0] state_i,
    input  logic [NIB-1:0]   sel_i,
    output logic [4*NIB-1:0] state_o
);

    localparam int HALF = NIB / 2;

    logic [3:0] sb_n [NIB];
    logic [3:0] lm_n [NIB];
    logic [3:0] pi_n [NIB];
    logic [3:0] pp_n [NIB];
    logic [3:0] ph_n [NIB];
    logic [7:0] pair_n;

    always_comb begin
        pair_n  = '0;
        state_o = '0;

        for (int i = 0; i < NIB; i++) begin
            sb_n[i] = sbox(sel_i[NIB-1-i], state_i[4*(NIB-1-i) +: 4]);
        end

        // L on (2i, 2i+1); the C half goes back to the even slot.
        for (int i = 0; i < HALF; i++) begin
            pair_n       = lmix(sb_n[2*i], sb_n[2*i+1]);
            lm_n[2*i]    = pair_n[7:4];
            lm_n[2*i+1]  = pair_n[3:0];
        end

        // pi: swap the upper two nibbles of every group of four.
        for (int i = 0; i < NIB; i += 4) begin
            pi_n[i]   = lm_n[i];
            pi_n[i+1] = lm_n[i+1];
            pi_n[i+2] = lm_n[i+3];
            pi_n[i+3] = lm_n[i+2];
        end

        // P': evens to the lower half, odds to the upper half.
        for (int i = 0; i < HALF; i++) begin
            pp_n[i]        = pi_n[2*i];
            pp_n[i + HALF] = pi_n[2*i+1];
        end

        // phi: swap adjacent nibbles in the upper half only.
        for (int i = 0; i < HALF; i++) begin
            ph_n[i] = pp_n[i];
        end
        for (int i = HALF; i < NIB; i += 2) begin
            ph_n[i]   = pp_n[i+1];
            ph_n[i+1] = pp_n[i];
        end

        for (int i = 0; i < NIB; i++) begin
            state_o[4*(NIB-1-i) +: 4] = ph_n[i];
        end
    end

endmodule

// File: rtl/f8.sv
// ---------------------------------------------------------------------------
// f8 -- iterative JH E8 permutation (compression F8 with an all-zero message).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    f8_if.slave: start / state_in in, state_out / done out
//
// Timing: an accepted start loads the grouped state and C0; the next 42
// clocks each apply one R8 round to the state and one R6 step to the
// constant.  The 42nd round edge also degroups straight into state_out and
// raises done, so done is seen 43 cycles after start.  A start while running
// or during the done cycle is dropped.
// ---------------------------------------------------------------------------
module f8
    import jh_pkg::*;
(
    input logic clk,
    input logic rst_n,
    f8_if.slave bus
);

    state_t             st_q,   st_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               done_q, done_d;
    logic [STATE_W-1:0] out_q,  out_d;
    logic [STATE_W-1:0] grp_q,  grp_d;
    logic [CONST_W-1:0] cst_q,  cst_d;

    logic [STATE_W-1:0] grp_rnd;
    logic [CONST_W-1:0] cst_rnd;
    logic               accept;
    logic               last_round;

    jh_round #(
        .NIB     (NIB_STATE)
    ) u_state_round (
        .state_i (grp_q),
        .sel_i   (cst_q),
        .state_o (grp_rnd)
    );

    jh_round #(
        .NIB     (NIB_CONST)
    ) u_const_round (
        .state_i (cst_q),
        .sel_i   ('0),
        .state_o (cst_rnd)
    );

    // Blocking start during the done cycle keeps each result visible for at
    // least one cycle before a new run can begin.
    assign accept     = bus.start && (st_q == ST_IDLE) && !done_q;
    assign last_round = (st_q == ST_RUN) && (cnt_q == CNT_W'(ROUNDS - 1));

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        out_d  = out_q;
        grp_d  = grp_q;
        cst_d  = cst_q;

        case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    st_d  = ST_RUN;
                    cnt_d = '0;
                    grp_d = group(bus.state_in);
                    cst_d = C0;
                end
            end
            ST_RUN: begin
                grp_d = grp_rnd;
                cst_d = cst_rnd;
                cnt_d = cnt_q + 1'b1;
                if (last_round) begin
                    st_d   = ST_IDLE;
                    done_d = 1'b1;
                    out_d  = degroup(grp_rnd);
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
            out_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            out_q  <= out_d;
        end
    end

    // Working state and constant are only meaningful while running, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        grp_q <= grp_d;
        cst_q <= cst_d;
    end

    assign bus.state_out = out_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_f8.sv
// ---------------------------------------------------------------------------
// tb_f8 -- bench for the f8 JH E8 engine.  Expected results come from an
// integer-array model of E8 built from the JH round definition and are
// queued when a start is driven, then popped when done is seen.
// ---------------------------------------------------------------------------
module tb_f8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    f8_if bus_if ();

    f8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1023:0] exp_q [$];
    logic [1023:0] last_exp;

    logic [1023:0] iv512  = 1024'h0200;
    logic [1023:0] iv256  = 1024'h0100;
    logic [127:0]  pre512 = 128'hd5437a152e05636aaa173e004b966fd1;
    logic [127:0]  pre256 = 128'h45c19cb2be7b92cdd3eb2c20a341eb98;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int sb0_t [16] = '{9, 0, 4, 11, 13, 12, 3, 15, 1, 10, 2, 6, 7, 5, 8, 14};
    int sb1_t [16] = '{3, 12, 6, 13, 5, 7, 1, 9, 15, 2, 0, 4, 11, 10, 14, 8};
    int wk  [256];
    int ta  [256];
    int tb  [256];
    int mq  [256];
    int cst [64];
    bit hh  [1024];

    function automatic void mdl_round(input int n, input bit use_c);
        int a, b, sel, j;
        int a0, a1, a2, a3, b0, b1, b2, b3;
        int c0, c1, c2, c3, d0, d1, d2, d3;
        for (int i = 0; i < n; i++) begin
            sel   = use_c ? ((cst[i / 4] >> (3 - i % 4)) & 1) : 0;
            ta[i] = (sel != 0) ? sb1_t[wk[i]] : sb0_t[wk[i]];
        end
        for (int i = 0; i < n / 2; i++) begin
            a  = ta[2*i];
            b  = ta[2*i+1];
            a0 = (a >> 3) & 1; a1 = (a >> 2) & 1; a2 = (a >> 1) & 1; a3 = a & 1;
            b0 = (b >> 3) & 1; b1 = (b >> 2) & 1; b2 = (b >> 1) & 1; b3 = b & 1;
            d0 = b0 ^ a1;
            d1 = b1 ^ a2;
            d2 = b2 ^ a3 ^ a0;
            d3 = b3 ^ a0;
            c0 = a0 ^ d1;
            c1 = a1 ^ d2;
            c2 = a2 ^ d3 ^ d0;
            c3 = a3 ^ d0;
            tb[2*i]   = c0 * 8 + c1 * 4 + c2 * 2 + c3;
            tb[2*i+1] = d0 * 8 + d1 * 4 + d2 * 2 + d3;
        end
        for (int i = 0; i < n; i++) begin
            j = i;
            if (i % 4 == 2) j = i + 1;
            else if (i % 4 == 3) j = i - 1;
            ta[i] = tb[j];
        end
        for (int i = 0; i < n / 2; i++) begin
            tb[i]         = ta[2*i];
            tb[i + n / 2] = ta[2*i+1];
        end
        for (int i = 0; i < n; i++) begin
            j = i;
            if (i >= n / 2) j = (i % 2 == 0) ? i + 1 : i - 1;
            wk[i] = tb[j];
        end
    endfunction

    function automatic logic [1023:0] model_e8(input logic [1023:0] v);
        logic [255:0]  cv;
        logic [7:0]    by;
        logic [1023:0] res;
        for (int k = 0; k < 1024; k++) begin
            by = (((k / 8) % 2) == 0) ? v[16*(k/16)+8 +: 8] : v[16*(k/16) +: 8];
            hh[k] = by[7 - (k % 8)];
        end
        for (int i = 0; i < 128; i++) begin
            mq[2*i]   = int'(hh[i]) * 8 + int'(hh[i+256]) * 4 + int'(hh[i+512]) * 2 + int'(hh[i+768]);
            mq[2*i+1] = int'(hh[i+128]) * 8 + int'(hh[i+384]) * 4 + int'(hh[i+640]) * 2 + int'(hh[i+896]);
        end
        cv = 256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;
        for (int i = 0; i < 64; i++) cst[i] = int'(cv[255-4*i -: 4]);
        for (int rd = 0; rd < 42; rd++) begin
            for (int i = 0; i < 256; i++) wk[i] = mq[i];
            mdl_round(256, 1'b1);
            for (int i = 0; i < 256; i++) mq[i] = wk[i];
            for (int i = 0; i < 64; i++) wk[i] = cst[i];
            mdl_round(64, 1'b0);
            for (int i = 0; i < 64; i++) cst[i] = wk[i];
        end
        for (int i = 0; i < 128; i++) begin
            hh[i]     = bit'((mq[2*i] >> 3) & 1);
            hh[i+256] = bit'((mq[2*i] >> 2) & 1);
            hh[i+512] = bit'((mq[2*i] >> 1) & 1);
            hh[i+768] = bit'(mq[2*i] & 1);
            hh[i+128] = bit'((mq[2*i+1] >> 3) & 1);
            hh[i+384] = bit'((mq[2*i+1] >> 2) & 1);
            hh[i+640] = bit'((mq[2*i+1] >> 1) & 1);
            hh[i+896] = bit'(mq[2*i+1] & 1);
        end
        res = '0;
        for (int bi = 0; bi < 128; bi++) begin
            for (int t = 0; t < 8; t++) by[7 - t] = hh[8*bi + t];
            if (bi % 2 == 0) res[16*(bi/2)+8 +: 8] = by;
            else             res[16*(bi/2) +: 8]   = by;
        end
        return res;
    endfunction

    function automatic logic [1023:0] rand_vec();
        logic [1023:0] v;
        for (int j = 0; j < 32; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    // First 16-bit word where two buses differ, for compact FAIL lines.
    function automatic int diff_word(input logic [1023:0] a, input logic [1023:0] b);
        for (int j = 0; j < 64; j++) begin
            if (a[16*j +: 16] !== b[16*j +: 16]) return j;
        end
        return 0;
    endfunction

    // Waits for done; cyc = cycle index (start cycle = 0) or -1 on timeout.
    // state_in is scrambled after the accepting edge.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus_if.start    = 1'b0;
                bus_if.state_in = ~bus_if.state_in;
            end
            if (bus_if.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n           = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.state_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", bus_if.done);
        end
        n_checks++;
        if (bus_if.state_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state_out: word %0d got %h expected 0000",
                     diff_word(bus_if.state_out, '0),
                     bus_if.state_out[16*diff_word(bus_if.state_out, '0) +: 16]);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_done: got %b expected 0", bus_if.done);
        end
    endtask

    task automatic test_iv(input string name, input logic [1023:0] iv, input logic [127:0] pre);
        int            cyc;
        int            w;
        logic [1023:0] e;
        bus_if.state_in = iv;
        exp_q.push_back(model_e8(iv));
        bus_if.start = 1'b1;
        wait_done(cyc);
        n_checks++;
        if (cyc !== 43) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected 43", name, cyc);
        end
        e = exp_q.pop_front();
        w = diff_word(bus_if.state_out, e);
        n_checks++;
        if (bus_if.state_out !== e) begin
            n_fail++;
            $display("FAIL %s_result: word %0d got %h expected %h", name, w,
                     bus_if.state_out[16*w +: 16], e[16*w +: 16]);
        end
        n_checks++;
        if (bus_if.state_out[127:0] !== pre) begin
            n_fail++;
            $display("FAIL %s_prefix: got %h expected %h", name, bus_if.state_out[127:0], pre);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse_width: done got %b expected 0", name, bus_if.done);
        end
        last_exp = e;
    endtask

    task automatic test_ignored_start();
        int            dones;
        int            first;
        int            w;
        logic [1023:0] e;
        dones           = 0;
        first           = -1;
        bus_if.state_in = rand_vec();
        exp_q.push_back(model_e8(bus_if.state_in));
        bus_if.start = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            if (k == 10) begin
                bus_if.state_in = rand_vec();
                bus_if.start    = 1'b1;
            end
            if (bus_if.done === 1'b1) begin
                dones++;
                if (first < 0) first = k;
            end
            if (k == 43) begin
                bus_if.state_in = rand_vec();
                bus_if.start    = 1'b1;
            end
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL busy_start_done_count: got %0d expected 1", dones);
        end
        n_checks++;
        if (first !== 43) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d expected 43", first);
        end
        e = exp_q.pop_front();
        w = diff_word(bus_if.state_out, e);
        n_checks++;
        if (bus_if.state_out !== e) begin
            n_fail++;
            $display("FAIL busy_start_result: word %0d got %h expected %h", w,
                     bus_if.state_out[16*w +: 16], e[16*w +: 16]);
        end
    endtask

    task automatic test_reset_mid();
        int            dones;
        int            cyc;
        int            w;
        logic [1023:0] e;
        bus_if.state_in = iv512;
        exp_q.push_back(model_e8(iv512));
        bus_if.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.state_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_state_out: word %0d got %h expected 0000",
                     diff_word(bus_if.state_out, '0),
                     bus_if.state_out[16*diff_word(bus_if.state_out, '0) +: 16]);
        end
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_done: got %b expected 0", bus_if.done);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", dones);
        end
        bus_if.state_in = iv512;
        exp_q.push_back(model_e8(iv512));
        bus_if.start = 1'b1;
        wait_done(cyc);
        n_checks++;
        if (cyc !== 43) begin
            n_fail++;
            $display("FAIL midreset_restart_latency: got %0d expected 43", cyc);
        end
        e = exp_q.pop_front();
        w = diff_word(bus_if.state_out, e);
        n_checks++;
        if (bus_if.state_out !== e) begin
            n_fail++;
            $display("FAIL midreset_restart_result: word %0d got %h expected %h", w,
                     bus_if.state_out[16*w +: 16], e[16*w +: 16]);
        end
        last_exp = e;
    endtask

    task automatic test_hold();
        int dones;
        int w;
        dones = 0;
        for (int k = 0; k < 100; k++) begin
            bus_if.state_in = rand_vec();
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1) dones++;
            n_checks++;
            if (bus_if.state_out !== last_exp) begin
                n_fail++;
                w = diff_word(bus_if.state_out, last_exp);
                $display("FAIL hold_state_out cycle %0d: word %0d got %h expected %h", k, w,
                         bus_if.state_out[16*w +: 16], last_exp[16*w +: 16]);
            end
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL hold_no_done: got %0d pulses expected 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int            cyc;
        int            w;
        logic [1023:0] e;
        for (int n = 0; n < 3; n++) begin
            bus_if.state_in = rand_vec();
            exp_q.push_back(model_e8(bus_if.state_in));
            bus_if.start = 1'b1;
            wait_done(cyc);
            n_checks++;
            if (cyc !== 43) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d expected 43", n, cyc);
            end
            e = exp_q.pop_front();
            w = diff_word(bus_if.state_out, e);
            n_checks++;
            if (bus_if.state_out !== e) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: word %0d got %h expected %h", n, w,
                         bus_if.state_out[16*w +: 16], e[16*w +: 16]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_iv("iv512", iv512, pre512);
        test_iv("iv256", iv256, pre256);
        test_ignored_start();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
